zpu_irq_ctrl: RTL

Interrupt controller and arbiter between the external interrupt lines and the zpu_core interrupt input. It latches events on up to 29 request lines and masks them with a software enable register. It picks one winner by fixed priority (lowest index wins) and runs a request/acknowledge/end-of-interrupt handshake with the core. Software reaches it through a small single-cycle register port on the core's Wishbone-style I/O space.

---
 rtl/zpu_irq_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/zpu_irq_ctrl.sv
// zpu_irq_ctrl: edge-latched interrupt arbiter for the zpu_core.
// Define ZPU_IRQ_LEVEL_EN to switch the request lines to level-sensitive latching.
module zpu_irq_ctrl #(
  parameter int NUM_IRQ = 29,
  parameter int VEC_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               reg_stb,
  input  logic               reg_we,
  input  logic [1:0]         reg_adr,
  input  logic [31:0]        reg_dat_i,
  output logic [31:0]        reg_dat_o,
  output logic               reg_ack,
  output logic               cpu_irq,
  output logic [VEC_W-1:0]   cpu_vec,
  input  logic               cpu_ack,
  input  logic               cpu_eoi
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SVC
  } state_t;

  localparam logic [31:0] MASK = 32'hFFFF_FFFF >> (32 - NUM_IRQ);

  state_t            state;
  state_t            state_nx;
  logic              grant;
  logic [31:0]       pending;
  logic [31:0]       pending_nx;
  logic [31:0]       enable;
  logic [31:0]       irq_w;
  logic [31:0]       set_hw;
  logic [31:0]       w1c;
  logic [31:0]       w1s;
  logic [31:0]       ack_clr;
  logic [31:0]       req;
  logic [31:0]       status;
  logic [31:0]       rdata;
  logic [VEC_W-1:0]  winner;
  logic              wr;

  assign irq_w = 32'(irq_in) & MASK;

`ifdef ZPU_IRQ_LEVEL_EN
  assign set_hw = irq_w;
`else
  logic [31:0] irq_prev;

  // previous line state for rising-edge detection
  always_ff @(posedge clk) begin
    if (rst) irq_prev <= '0;
    else     irq_prev <= irq_w;
  end

  assign set_hw = irq_w & ~irq_prev;
`endif

  assign wr  = reg_stb & reg_we;
  assign w1c = (wr && reg_adr == 2'd0) ? (reg_dat_i & MASK) : '0;
  assign w1s = (wr && reg_adr == 2'd3) ? (reg_dat_i & MASK) : '0;
  assign ack_clr = (state == REQ && cpu_ack) ? (32'd1 << cpu_vec) : '0;
  assign req = pending & enable;

  // sets are applied after clears so a same-cycle set always wins
  assign pending_nx = ((pending & ~w1c & ~ack_clr) | set_hw | w1s) & MASK;

  // lowest set index of req wins
  always_comb begin
    winner = '0;
    for (int i = 31; i >= 0; i--) begin
      if (req[i]) winner = VEC_W'(i);
    end
  end

  // next-state decode of the core handshake
  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          grant    = 1'b1;
          state_nx = REQ;
        end
      end
      REQ: begin
        if (cpu_ack) state_nx = SVC;
      end
      SVC: begin
        if (cpu_eoi) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // handshake state and the latched vector
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cpu_vec <= '0;
    end else begin
      state <= state_nx;
      if (grant) cpu_vec <= winner;
    end
  end

  assign cpu_irq = (state == REQ);

  // pending and enable registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      enable  <= '0;
    end else begin
      pending <= pending_nx;
      if (wr && reg_adr == 2'd1) enable <= reg_dat_i & MASK;
    end
  end

  always_comb begin
    status                 = '0;
    status[31]             = (state == SVC);
    status[VEC_W-1:0]      = cpu_vec;
  end

  // read mux; SOFTSET is write-only
  always_comb begin
    rdata = '0;
    unique case (reg_adr)
      2'd0: rdata = pending;
      2'd1: rdata = enable;
      2'd2: rdata = status;
      2'd3: rdata = '0;
    endcase
  end

  // single-cycle registered acknowledge and read data
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_ack   <= 1'b0;
      reg_dat_o <= '0;
    end else begin
      reg_ack   <= reg_stb;
      reg_dat_o <= (reg_stb && !reg_we) ? rdata : '0;
    end
  end

endmodule
